// File: rtl/circle_seg_driver.sv
// Seven-segment "circle" driver: lights the upper or lower circle on one display
// and optionally keeps the previous position lit as a fading trail for a while.
module circle_seg_driver #(
   parameter int NO_DISPLAYS  = 6,
   parameter int TRAIL_CYCLES = 12_500_000
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic                       row_i,
   input  logic [2:0]                 col_i,
   output logic [7*NO_DISPLAYS-1:0]   seg_o,
   output logic                       err_o
);

   localparam int             CNT_W     = (TRAIL_CYCLES > 0) ? $clog2(TRAIL_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'((TRAIL_CYCLES > 0) ? TRAIL_CYCLES - 1 : 0);
   localparam logic [3:0]     NDISP     = 4'(NO_DISPLAYS);
   localparam logic [6:0]     SEG_UPPER = 7'b0011100;
   localparam logic [6:0]     SEG_LOWER = 7'b0100011;
   localparam logic [6:0]     SEG_BLANK = 7'h7F;

   typedef enum logic {IDLE, TRAIL} state_t;

   state_t                   r_state;
   state_t                   w_stateNext;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cntNext;
   logic                     r_curRow;
   logic [2:0]               r_curCol;
   logic                     r_prevRow;
   logic [2:0]               r_prevCol;
   logic                     r_err;
   logic [7*NO_DISPLAYS-1:0] r_seg;
   logic [7*NO_DISPLAYS-1:0] w_segNext;
   logic                     w_valid;
   logic                     w_move;
   logic [6:0]               w_curCode;
   logic [6:0]               w_prevCode;

   assign w_valid = ({1'b0, col_i} < NDISP);
   assign w_move  = w_valid && ({row_i, col_i} != {r_curRow, r_curCol});

   // Position capture keeps running even while the display is disabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_curRow  <= 1'b1;
         r_curCol  <= 3'd0;
         r_prevRow <= 1'b1;
         r_prevCol <= 3'd0;
         r_err     <= 1'b0;
      end else begin
         if (w_valid) begin
            r_curRow <= row_i;
            r_curCol <= col_i;
         end
         if (w_move) begin
            r_prevRow <= r_curRow;
            r_prevCol <= r_curCol;
         end
         if (!w_valid) begin
            r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   // A move always restarts the full trail, even if one is already showing.
   always_comb begin
      w_stateNext = IDLE;
      w_cntNext   = '0;
      if (!en_i) begin
         w_stateNext = IDLE;
         w_cntNext   = '0;
      end else if (w_move && (TRAIL_CYCLES > 0)) begin
         w_stateNext = TRAIL;
         w_cntNext   = RELOAD;
      end else if (r_state == TRAIL) begin
         if (r_cnt == '0) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end else begin
            w_stateNext = TRAIL;
            w_cntNext   = r_cnt - CNT_W'(1);
         end
      end
   end

   assign w_curCode  = r_curRow  ? SEG_UPPER : SEG_LOWER;
   assign w_prevCode = r_prevRow ? SEG_UPPER : SEG_LOWER;

   // Segments are active-low, so AND-ing two codes lights the union of both.
   always_comb begin
      w_segNext = '1;
      for (int k = 0; k < NO_DISPLAYS; k++) begin
         w_segNext[7*k +: 7] = SEG_BLANK;
         if (r_curCol == 3'(k)) begin
            w_segNext[7*k +: 7] = w_curCode;
         end
         if ((r_state == TRAIL) && (r_prevCol == 3'(k))) begin
            w_segNext[7*k +: 7] = w_segNext[7*k +: 7] & w_prevCode;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_seg <= '1;
      end else begin
         r_seg <= en_i ? w_segNext : '1;
      end
   end

   assign seg_o = r_seg;
   assign err_o = r_err;

endmodule

// File: tb/tb_circle_seg_driver.sv
// Scoreboard bench for circle_seg_driver: stimulus pushes predicted outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_circle_seg_driver;

   localparam int NDISP = 6;
   localparam int TRAIL = 4;
   localparam int SW    = 7 * NDISP;

   logic          clk_i  = 1'b0;
   logic          rst_ni = 1'b0;
   logic          en_i   = 1'b0;
   logic          row_i  = 1'b1;
   logic [2:0]    col_i  = 3'd0;
   logic [SW-1:0] seg_o;
   logic          err_o;

   circle_seg_driver #(
      .NO_DISPLAYS  (NDISP),
      .TRAIL_CYCLES (TRAIL)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en_i),
      .row_i  (row_i),
      .col_i  (col_i),
      .seg_o  (seg_o),
      .err_o  (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [SW-1:0] seg;
      logic          err;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;

   // Reference model: positions plus number of edges the trail remains visible.
   int mCurRow, mCurCol, mPrevRow, mPrevCol, mTrailLeft;
   bit mErr;

   function automatic logic [6:0] rowCode(input int r);
      return (r != 0) ? 7'b0011100 : 7'b0100011;
   endfunction

   function automatic logic [SW-1:0] modelSeg(input bit en);
      logic [SW-1:0] s;
      logic [6:0]    d;
      s = '1;
      if (!en) return s;
      for (int k = 0; k < NDISP; k++) begin
         d = 7'h7F;
         if (k == mCurCol) d = rowCode(mCurRow);
         if (mTrailLeft > 0 && k == mPrevCol) d = d & rowCode(mPrevRow);
         s[7*k +: 7] = d;
      end
      return s;
   endfunction

   task automatic modelReset();
      mCurRow    = 1;
      mCurCol    = 0;
      mPrevRow   = 1;
      mPrevCol   = 0;
      mTrailLeft = 0;
      mErr       = 0;
   endtask

   task automatic checkOutput(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs and predict what the outputs show after that edge.
   task automatic applyStimulus(input bit en, input bit row, input int col);
      exp_t e;
      bit   move;
      @(negedge clk_i);
      en_i  = en;
      row_i = row;
      col_i = 3'(col);
      e.seg = modelSeg(en);
      if (col >= NDISP) mErr = 1;
      move = (col < NDISP) && ((int'(row) != mCurRow) || (col != mCurCol));
      if (move) begin
         mPrevRow = mCurRow;
         mPrevCol = mCurCol;
         mCurRow  = int'(row);
         mCurCol  = col;
      end
      if (!en)                 mTrailLeft = 0;
      else if (move)           mTrailLeft = TRAIL;
      else if (mTrailLeft > 0) mTrailLeft--;
      e.err = mErr;
      expQ.push_back(e);
   endtask

   task automatic hold(input bit en, input bit row, input int col, input int n);
      repeat (n) applyStimulus(en, row, col);
   endtask

   task automatic doReset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      en_i   = 1'b1;
      row_i  = 1'b1;
      col_i  = 3'd0;
      #1;
      checkOutput("rst_seg", seg_o, '1);
      checkOutput("rst_err", SW'(err_o), '0);
      modelReset();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   always @(posedge clk_i) begin
      #1;
      if (rst_ni && expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput("seg", seg_o, monE.seg);
         checkOutput("err", SW'(err_o), SW'(monE.err));
      end
   end

   initial begin
      modelReset();
      doReset();
      hold(1, 1, 0, 4);
      hold(1, 1, 1, 8);
      hold(1, 1, 5, 3);
      hold(1, 0, 5, 8);
      hold(1, 1, 2, 2);
      hold(1, 1, 3, 2);
      hold(1, 0, 3, 7);
      hold(1, 1, 4, 2);
      hold(0, 1, 4, 2);
      hold(1, 1, 4, 4);
      hold(1, 0, 7, 1);
      hold(1, 1, 4, 3);
      hold(1, 0, 1, 2);
      doReset();
      hold(1, 1, 0, 3);
      repeat (80) begin
         hold(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), int'($urandom_range(1, 6)));
      end
      repeat (2) @(negedge clk_i);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/circle_seg_driver.md
CIRCLE_SEG_DRIVER -- requirements
Module: circle_seg_driver

Interface
REQ-001 Parameter NO_DISPLAYS, default 6: number of seven-segment displays driven (valid col 0..NO_DISPLAYS-1).
REQ-002 Parameter TRAIL_CYCLES, default 12_500_000: clock cycles the previous position stays lit after a move; 0 disables the trail.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  display enable; 0 blanks all displays.
REQ-006 row_i  input  1  circle row from the position generator: 1 = upper circle, 0 = lower circle.
REQ-007 col_i  input  3  circle column (display index) from the position generator.
REQ-008 seg_o  output  7*NO_DISPLAYS  active-low segments, display k at bits [7k+6:7k], bit order {g,f,e,d,c,b,a}.
REQ-009 err_o  output  1  sticky flag, set on any out-of-range col_i.

Function
REQ-010 Segment codes SHALL be: upper circle (a,b,f,g) 7'b0011100; lower circle (c,d,e,g) 7'b0100011; blank 7'h7F.
REQ-011 Input stage SHALL register row_i/col_i each cycle into cur_row/cur_col only when col_i < NO_DISPLAYS; otherwise the old value is held.
REQ-012 col_i >= NO_DISPLAYS SHALL set err_o on the next edge; err_o SHALL clear only by reset.
REQ-013 A move SHALL be detected when a valid sampled {row_i,col_i} differs from {cur_row,cur_col}; on a move {prev_row,prev_col} <= {cur_row,cur_col}.
REQ-014 State machine: IDLE (no trail) and TRAIL (trail lit); trail counter width $clog2(TRAIL_CYCLES+1).
REQ-015 IDLE -> TRAIL on a move when TRAIL_CYCLES > 0 and en_i = 1; counter loads TRAIL_CYCLES-1.
REQ-016 In TRAIL the counter SHALL decrement each cycle; TRAIL -> IDLE on the cycle the counter is 0 with no move.
REQ-017 A move during TRAIL SHALL update prev to the old current position and reload the counter to TRAIL_CYCLES-1, staying in TRAIL.
REQ-018 en_i = 0 SHALL force IDLE and clear the counter; position capture, move detection and err_o continue.
REQ-019 Display k pattern SHALL be the current-position code if k = cur_col, AND (bitwise, active-low union) the previous-position code if state = TRAIL and k = prev_col; blank otherwise.
REQ-020 Trail and current on the same display, different rows, SHALL yield 7'b0000000 (both circles lit); same row yields the single code.
REQ-021 seg_o SHALL be registered; with en_i = 0 it SHALL be all 1s.
REQ-022 Latency: a valid input sampled at edge N SHALL appear on seg_o after edge N+1 (two registers).
REQ-023 No combinational path SHALL exist from any input to any output.

Reset
REQ-024 On rst_ni = 0: cur_row = 1, cur_col = 0, prev_row = 1, prev_col = 0, state IDLE, counter 0, err_o = 0, seg_o all 1s.
REQ-025 After reset release with en_i = 1 and stable input {1,0}, seg_o SHALL show 7'b0011100 on display 0 and blank elsewhere by the second edge.
REQ-026 Reset asserted mid-TRAIL SHALL immediately clear all state and outputs to REQ-024 values.

Verification
REQ-027 Reset, en_i=1, row=1 col=0 -> seg_o[6:0]=7'b0011100, all other displays 7'h7F, err_o=0.
REQ-028 TRAIL_CYCLES=4, move {1,0}->{1,1} at edge N -> display 1=0011100 and display 0=0011100 for 4 cycles, display 0 blank afterwards.
REQ-029 TRAIL_CYCLES=4, move {1,5}->{0,5} -> display 5 = 7'b0000000 for 4 cycles, then 7'b0100011.
REQ-030 Second move 2 cycles into TRAIL -> trail jumps to the latest previous position, counter restarts, full 4-cycle trail observed.
REQ-031 col_i=7 for one cycle -> err_o=1 from next edge onward, seg_o unchanged, err_o persists until reset.
REQ-032 en_i=0 during TRAIL -> seg_o all 1s next edge; en_i=1 again -> only current position lit, no trail.
